// File: rtl/ram_master.sv
// ram_master
//
// Bus initiator for an 8-entry RAM. It turns single or burst (1-8 beat)
// read/write requests from a client into RAM chip-select cycles. Write data
// arrives on a valid/ready stream. Read data leaves on a registered
// valid/ready stream that honours backpressure.
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   Reset       synchronous, active-high reset
//   ReqValid    request present
//   ReqReady    request accepted this cycle (IDLE only)
//   ReqWrite    1 = write burst, 0 = read burst
//   ReqAddr     burst start address
//   ReqLen      beats minus one
//   WrData      write beat data
//   WrValid     write beat present
//   WrReady     write beat consumed at this edge
//   RdData      registered read data
//   RdValid     RdData valid
//   RdReady     client consumes RdData at this edge
//   RdLast      marks the final read beat of a burst
//   Done        one-cycle pulse when a burst completes
//   RamCS       RAM chip select
//   RamRWS      RAM direction (1 = write, 0 = read)
//   RamAddress  RAM address
//   RamDataIn   RAM write data
//   RamDataOut  RAM read data (only meaningful during read cycles)

module ram_master #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqWrite,
    input  logic [2:0]       ReqAddr,
    input  logic [2:0]       ReqLen,
    input  logic [WIDTH-1:0] WrData,
    input  logic             WrValid,
    output logic             WrReady,
    output logic [WIDTH-1:0] RdData,
    output logic             RdValid,
    input  logic             RdReady,
    output logic             RdLast,
    output logic             Done,
    output logic             RamCS,
    output logic             RamRWS,
    output logic [2:0]       RamAddress,
    output logic [WIDTH-1:0] RamDataIn,
    input  logic [WIDTH-1:0] RamDataOut
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cur_addr_q, cur_addr_d;
    logic [2:0]       count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q, rd_last_d;
    logic             done_q, done_d;

    logic             cs_raw;
    logic             rws;
    logic             wr_ready_raw;
    logic             req_ready_raw;
    logic             issue;

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        count_d       = count_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;
        rd_last_d     = rd_last_q;
        done_d        = 1'b0;
        cs_raw        = 1'b0;
        rws           = 1'b0;
        wr_ready_raw  = 1'b0;
        req_ready_raw = 1'b0;
        issue         = 1'b0;

        // A consumed read beat retires unless a new read replaces it below.
        if (rd_valid_q && RdReady) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                req_ready_raw = 1'b1;
                if (ReqValid) begin
                    cur_addr_d = ReqAddr;
                    count_d    = ReqLen;
                    state_d    = ReqWrite ? WRITE : READ;
                end
            end

            WRITE: begin
                rws          = 1'b1;
                wr_ready_raw = 1'b1;
                cs_raw       = WrValid;
                if (WrValid) begin
                    cur_addr_d = cur_addr_q + 3'd1;
                    count_d    = count_q - 3'd1;
                    if (count_q == 3'd0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            READ: begin
                // Only fetch when the output register is free or being emptied,
                // so RdData stays stable under backpressure.
                issue  = !rd_valid_q || RdReady;
                cs_raw = issue;
                if (issue) begin
                    rd_data_d  = RamDataOut;
                    rd_valid_d = 1'b1;
                    rd_last_d  = (count_q == 3'd0);
                    cur_addr_d = cur_addr_q + 3'd1;
                    count_d    = count_q - 3'd1;
                    if (count_q == 3'd0) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Burst finishes only once the last beat has been taken.
                if (rd_valid_q && RdReady) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            cur_addr_q <= 3'd0;
            count_q    <= 3'd0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
        end
    end

    // Handshakes and chip select are suppressed while Reset is high so an
    // abandoned burst cannot write the RAM or accept anything on that edge.
    assign RamCS      = cs_raw & ~Reset;
    assign WrReady    = wr_ready_raw & ~Reset;
    assign ReqReady   = req_ready_raw & ~Reset;
    assign RamRWS     = rws;
    assign RamAddress = cur_addr_q;
    assign RamDataIn  = WrData;
    assign RdData     = rd_data_q;
    assign RdValid    = rd_valid_q;
    assign RdLast     = rd_last_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master
//
// Self-checking bench for ram_master. A behavioural 8-entry RAM hangs off the
// RAM port. Expected RAM writes and expected read beats are queued when the
// stimulus is issued. A monitor pops and compares them whenever the DUT
// writes the RAM or hands over a read beat.

module tb_ram_master;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             Reset;
    logic             ReqValid;
    logic             ReqReady;
    logic             ReqWrite;
    logic [2:0]       ReqAddr;
    logic [2:0]       ReqLen;
    logic [WIDTH-1:0] WrData;
    logic             WrValid;
    logic             WrReady;
    logic [WIDTH-1:0] RdData;
    logic             RdValid;
    logic             RdReady;
    logic             RdLast;
    logic             Done;
    logic             RamCS;
    logic             RamRWS;
    logic [2:0]       RamAddress;
    logic [WIDTH-1:0] RamDataIn;
    wire  [WIDTH-1:0] RamDataOut;

    logic [WIDTH-1:0] ram_mem [8];
    logic [WIDTH-1:0] ref_mem [8];
    logic [10:0]      exp_wr_q [$];
    logic [8:0]       exp_rd_q [$];
    int               checks = 0;
    int               errors = 0;
    int               ram_writes = 0;

    always #5 CLK = ~CLK;

    ram_master #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqAddr    (ReqAddr),
        .ReqLen     (ReqLen),
        .WrData     (WrData),
        .WrValid    (WrValid),
        .WrReady    (WrReady),
        .RdData     (RdData),
        .RdValid    (RdValid),
        .RdReady    (RdReady),
        .RdLast     (RdLast),
        .Done       (Done),
        .RamCS      (RamCS),
        .RamRWS     (RamRWS),
        .RamAddress (RamAddress),
        .RamDataIn  (RamDataIn),
        .RamDataOut (RamDataOut)
    );

    // Behavioural RAM: cleared by Reset, written on CS&RWS edges, drives its
    // output only while being read.
    always @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) ram_mem[i] <= '0;
        end else if (RamCS && RamRWS) begin
            ram_mem[RamAddress] <= RamDataIn;
        end
    end

    assign RamDataOut = (RamCS && !RamRWS) ? ram_mem[RamAddress] : 'z;

    // Scoreboard monitor, sampling mid-cycle after the bench has driven inputs.
    always @(negedge CLK) begin
        logic [10:0] ew;
        logic [8:0]  er;
        #2;
        if (RamCS === 1'b1 && RamRWS === 1'b1) begin
            ram_writes++;
            checks++;
            if (exp_wr_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL ram_write: got addr=%0d data=%h, want no write", RamAddress, RamDataIn);
            end else begin
                ew = exp_wr_q.pop_front();
                if ({RamAddress, RamDataIn} !== ew) begin
                    errors++;
                    $display("[TB] FAIL ram_write: got addr=%0d data=%h, want addr=%0d data=%h",
                             RamAddress, RamDataIn, ew[10:8], ew[7:0]);
                end
            end
        end
        if (RdValid === 1'b1 && RdReady === 1'b1) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL read_beat: got data=%h last=%b, want no beat", RdData, RdLast);
            end else begin
                er = exp_rd_q.pop_front();
                if ({RdLast, RdData} !== er) begin
                    errors++;
                    $display("[TB] FAIL read_beat: got data=%h last=%b, want data=%h last=%b",
                             RdData, RdLast, er[7:0], er[8]);
                end
            end
        end
    end

    function automatic void expect_write(input logic [2:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        exp_wr_q.push_back({a, d});
    endfunction

    function automatic void expect_read(input logic [2:0] a, input logic [2:0] len);
        logic [2:0] ad;
        for (int i = 0; i <= int'(len); i++) begin
            ad = 3'(int'(a) + i);
            exp_rd_q.push_back({(i == int'(len)), ref_mem[ad]});
        end
    endfunction

    // Presents a request until ReqReady is seen; returns at the negedge after
    // the accepting edge with ReqValid dropped.
    task automatic send_req(input logic w, input logic [2:0] a, input logic [2:0] len, output bit ok);
        ok = 1'b0;
        @(negedge CLK);
        ReqValid = 1'b1;
        ReqWrite = w;
        ReqAddr  = a;
        ReqLen   = len;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (ReqReady === 1'b1) ok = 1'b1;
            @(negedge CLK);
        end
        ReqValid = 1'b0;
    endtask

    // Called at a negedge; offers one write beat until WrReady is seen.
    task automatic drive_beat(input logic [7:0] d, output bit ok);
        ok      = 1'b0;
        WrValid = 1'b1;
        WrData  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (WrReady === 1'b1) ok = 1'b1;
            @(negedge CLK);
        end
        WrValid = 1'b0;
    endtask

    // Called at a negedge while a read burst runs; holds off the first beat
    // for stall_len cycles, then consumes every beat until Done is seen.
    task automatic run_read(input int stall_len, output int beats, output int first_c,
                            output int last_c, output int done_c, output int stalls,
                            output int stall_bad);
        logic [7:0] held;
        beats = 0; first_c = -1; last_c = -1; done_c = -1;
        stalls = 0; stall_bad = 0; held = '0;
        for (int c = 0; c < 60 && done_c < 0; c++) begin
            RdReady = !(beats == 0 && stalls < stall_len && RdValid === 1'b1);
            #1;
            if (Done === 1'b1) done_c = c;
            if (!RdReady) begin
                if (stalls == 0) held = RdData;
                else if (RdData !== held) stall_bad++;
                if (RamCS !== 1'b0) stall_bad++;
                stalls++;
            end else if (RdValid === 1'b1) begin
                if (beats == 0) first_c = c;
                last_c = c;
                beats++;
            end
            @(negedge CLK);
        end
        RdReady = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        Reset = 1'b1; ReqValid = 1'b1; ReqWrite = 1'b1; WrValid = 1'b1;
        #1;
        checks++; if (ReqReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 0", ReqReady); end
        checks++; if (RamCS !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_cs: got %b want 0", RamCS); end
        checks++; if (WrReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_ready: got %b want 0", WrReady); end
        @(negedge CLK);
        ReqValid = 1'b0; ReqWrite = 1'b0; WrValid = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle_ready: got %b want 1", ReqReady); end
        checks++; if ({RdValid, RdLast, Done} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 000", {RdValid, RdLast, Done}); end
        checks++; if (RdData !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got %h want 00", RdData); end
        checks++; if (RamAddress !== 3'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", RamAddress); end
    endtask

    task automatic test_single();
        bit ok; bit all_ok; int w0;
        all_ok = 1'b1;
        w0 = ram_writes;
        expect_write(3'd3, 8'hA5);
        send_req(1'b1, 3'd3, 3'd0, ok); all_ok &= ok;
        drive_beat(8'hA5, ok); all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("[TB] FAIL single_wr_handshake: got timeout want accept"); end
        #1;
        checks++; if ({Done, ReqReady} !== 2'b11) begin errors++; $display("[TB] FAIL single_wr_done: got %b want 11", {Done, ReqReady}); end
        @(negedge CLK); #1;
        checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL single_wr_done_width: got %b want 0", Done); end
        checks++; if (ram_writes - w0 != 1) begin errors++; $display("[TB] FAIL single_wr_count: got %0d want 1", ram_writes - w0); end
        expect_read(3'd3, 3'd0);
        RdReady = 1'b1;
        send_req(1'b0, 3'd3, 3'd0, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL single_rd_accept: got timeout want accept"); end
        #1;
        checks++; if (RdValid !== 1'b0) begin errors++; $display("[TB] FAIL single_rd_early: got %b want 0", RdValid); end
        @(negedge CLK); #1;
        checks++; if ({RdValid, RdLast, RdData} !== {2'b11, 8'hA5}) begin errors++; $display("[TB] FAIL single_rd_beat: got v=%b l=%b d=%h want v=1 l=1 d=a5", RdValid, RdLast, RdData); end
        @(negedge CLK); #1;
        checks++; if ({Done, RdValid} !== 2'b10) begin errors++; $display("[TB] FAIL single_rd_done: got %b want 10", {Done, RdValid}); end
        @(negedge CLK);
    endtask

    task automatic test_wrap_burst();
        bit ok; bit all_ok;
        logic [7:0] d [4];
        int beats, first_c, last_c, done_c, stalls, stall_bad;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) expect_write(3'(6 + i), d[i]);
        send_req(1'b1, 3'd6, 3'd3, ok); all_ok &= ok;
        for (int i = 0; i < 4; i++) begin drive_beat(d[i], ok); all_ok &= ok; end
        checks++; if (!all_ok) begin errors++; $display("[TB] FAIL wrap_wr_handshake: got timeout want accept"); end
        #1;
        checks++; if (Done !== 1'b1) begin errors++; $display("[TB] FAIL wrap_wr_done: got %b want 1", Done); end
        checks++; if (exp_wr_q.size() != 0) begin errors++; $display("[TB] FAIL wrap_wr_left: got %0d pending want 0", exp_wr_q.size()); end
        @(negedge CLK);
        expect_read(3'd6, 3'd3);
        RdReady = 1'b1;
        send_req(1'b0, 3'd6, 3'd3, ok);
        run_read(0, beats, first_c, last_c, done_c, stalls, stall_bad);
        checks++; if (beats != 4) begin errors++; $display("[TB] FAIL wrap_rd_beats: got %0d want 4", beats); end
        checks++; if (last_c - first_c != 3) begin errors++; $display("[TB] FAIL wrap_rd_span: got %0d want 3", last_c - first_c); end
        checks++; if (done_c - last_c != 1) begin errors++; $display("[TB] FAIL wrap_rd_done: got gap %0d want 1", done_c - last_c); end
    endtask

    task automatic test_write_stall();
        bit ok; bit all_ok; int w0; int gap_bad;
        int beats, first_c, last_c, done_c, stalls, stall_bad;
        all_ok = 1'b1; gap_bad = 0;
        w0 = ram_writes;
        expect_write(3'd4, 8'hAA); expect_write(3'd5, 8'hBB); expect_write(3'd6, 8'hCC);
        send_req(1'b1, 3'd4, 3'd2, ok); all_ok &= ok;
        drive_beat(8'hAA, ok); all_ok &= ok;
        for (int i = 0; i < 2; i++) begin
            #1;
            if (RamCS !== 1'b0 || RamAddress !== 3'd5) gap_bad++;
            @(negedge CLK);
        end
        drive_beat(8'hBB, ok); all_ok &= ok;
        drive_beat(8'hCC, ok); all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("[TB] FAIL stall_wr_handshake: got timeout want accept"); end
        checks++; if (gap_bad != 0) begin errors++; $display("[TB] FAIL stall_wr_gap: got %0d bad gap cycles want 0", gap_bad); end
        #1;
        checks++; if (Done !== 1'b1) begin errors++; $display("[TB] FAIL stall_wr_done: got %b want 1", Done); end
        @(negedge CLK);
        checks++; if (ram_writes - w0 != 3) begin errors++; $display("[TB] FAIL stall_wr_count: got %0d want 3", ram_writes - w0); end
        expect_read(3'd4, 3'd2);
        send_req(1'b0, 3'd4, 3'd2, ok);
        run_read(0, beats, first_c, last_c, done_c, stalls, stall_bad);
        checks++; if (beats != 3 || done_c < 0) begin errors++; $display("[TB] FAIL stall_rd_beats: got %0d done_at=%0d want 3 with done", beats, done_c); end
    endtask

    task automatic test_read_backpressure();
        bit ok;
        int beats, first_c, last_c, done_c, stalls, stall_bad;
        expect_read(3'd4, 3'd3);
        send_req(1'b0, 3'd4, 3'd3, ok);
        run_read(3, beats, first_c, last_c, done_c, stalls, stall_bad);
        checks++; if (stalls != 3) begin errors++; $display("[TB] FAIL bp_stalls: got %0d want 3", stalls); end
        checks++; if (stall_bad != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d violations want 0", stall_bad); end
        checks++; if (beats != 4 || last_c - first_c != 3) begin errors++; $display("[TB] FAIL bp_beats: got %0d span %0d want 4 span 3", beats, last_c - first_c); end
        checks++; if (exp_rd_q.size() != 0 || done_c < 0) begin errors++; $display("[TB] FAIL bp_done: got %0d pending done_at=%0d want 0 with done", exp_rd_q.size(), done_c); end
    endtask

    task automatic test_back_to_back();
        bit done_seen; int busy_bad;
        int beats, first_c, last_c, done_c, stalls, stall_bad;
        done_seen = 1'b0; busy_bad = 0;
        expect_read(3'd6, 3'd3);
        expect_read(3'd0, 3'd1);
        RdReady = 1'b1;
        @(negedge CLK);
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqAddr = 3'd6; ReqLen = 3'd3;
        #1;
        checks++; if (ReqReady !== 1'b1) begin errors++; $display("[TB] FAIL busy_first_accept: got %b want 1", ReqReady); end
        @(negedge CLK);
        ReqAddr = 3'd0; ReqLen = 3'd1;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            #1;
            if (Done === 1'b1) begin
                done_seen = 1'b1;
                checks++; if (ReqReady !== 1'b1) begin errors++; $display("[TB] FAIL busy_done_ready: got %b want 1", ReqReady); end
            end else if (ReqReady !== 1'b0) begin
                busy_bad++;
            end
            @(negedge CLK);
        end
        ReqValid = 1'b0;
        checks++; if (!done_seen) begin errors++; $display("[TB] FAIL busy_done: got timeout want Done"); end
        checks++; if (busy_bad != 0) begin errors++; $display("[TB] FAIL busy_ready_low: got %0d ready cycles want 0", busy_bad); end
        run_read(0, beats, first_c, last_c, done_c, stalls, stall_bad);
        checks++; if (beats != 2 || done_c < 0) begin errors++; $display("[TB] FAIL busy_second: got %0d beats done_at=%0d want 2 with done", beats, done_c); end
        checks++; if (exp_rd_q.size() != 0) begin errors++; $display("[TB] FAIL busy_left: got %0d pending want 0", exp_rd_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok; bit all_ok; int w0;
        int beats, first_c, last_c, done_c, stalls, stall_bad;
        all_ok = 1'b1;
        w0 = ram_writes;
        expect_write(3'd2, 8'h51); expect_write(3'd3, 8'h52);
        send_req(1'b1, 3'd2, 3'd7, ok); all_ok &= ok;
        drive_beat(8'h51, ok); all_ok &= ok;
        drive_beat(8'h52, ok); all_ok &= ok;
        checks++; if (!all_ok) begin errors++; $display("[TB] FAIL mid_wr_handshake: got timeout want accept"); end
        WrValid = 1'b1; WrData = 8'h53; Reset = 1'b1;
        #1;
        checks++; if ({RamCS, WrReady, ReqReady} !== 3'b000) begin errors++; $display("[TB] FAIL mid_reset_gate: got %b want 000", {RamCS, WrReady, ReqReady}); end
        @(negedge CLK);
        Reset = 1'b0; WrValid = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        #1;
        checks++; if ({ReqReady, RdValid, Done} !== 3'b100) begin errors++; $display("[TB] FAIL mid_idle: got %b want 100", {ReqReady, RdValid, Done}); end
        @(negedge CLK); #1;
        checks++; if (Done !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_done: got %b want 0", Done); end
        checks++; if (ram_writes - w0 != 2) begin errors++; $display("[TB] FAIL mid_wr_count: got %0d want 2", ram_writes - w0); end
        expect_read(3'd2, 3'd1);
        send_req(1'b0, 3'd2, 3'd1, ok);
        run_read(0, beats, first_c, last_c, done_c, stalls, stall_bad);
        checks++; if (beats != 2 || done_c < 0) begin errors++; $display("[TB] FAIL mid_readback: got %0d beats done_at=%0d want 2 with done", beats, done_c); end
    endtask

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqLen = '0;
        WrData = '0; WrValid = 1'b0; RdReady = 1'b1;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        test_reset();
        test_single();
        test_wrap_burst();
        test_write_stall();
        test_read_backpressure();
        test_back_to_back();
        test_reset_mid_burst();
        @(negedge CLK);
        checks++; if (exp_wr_q.size() + exp_rd_q.size() != 0) begin errors++; $display("[TB] FAIL final_queues: got %0d pending want 0", exp_wr_q.size() + exp_rd_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
